// File: rtl/ar9331_rx_link.sv
// Receive side of the AR9331 toggle-handshake link: strobe synchroniser,
// frame parser (header, 16-bit length, payload) and command FIFO writer.
module ar9331_rx_link #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  HEADER      = 8'd54,
    parameter int unsigned TIMEOUT     = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        strb_in,
    input  logic [7:0]  data_in,
    output logic        ack_out,
    input  logic        fifo_full,
    output logic        wr_en,
    output logic [7:0]  wr_data,
    output logic [15:0] len_out,
    output logic        frame_start,
    output logic        frame_done,
    output logic        frame_err,
    output logic        busy
);

    localparam int unsigned CNT_W    = 16;
    localparam int unsigned ARM_LAST = SYNC_STAGES + 1;
    localparam int unsigned ARM_W    = $clog2(SYNC_STAGES + 2);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LEN_H   = 2'd1,
        ST_LEN_L   = 2'd2,
        ST_PAYLOAD = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   strb_prev_q, strb_prev_d;
    logic [ARM_W-1:0]       arm_q;
    logic [CNT_W-1:0]       byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0]       tmo_q, tmo_d;
    logic                   ack_q, ack_d;
    logic                   wr_en_q, wr_en_d;
    logic [7:0]             wr_data_q, wr_data_d;
    logic [15:0]            len_q, len_d;
    logic                   start_q, start_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   busy_q, busy_d;

    logic strb_sync_c;
    logic armed_c;
    logic event_c;
    logic accept_c;

    assign strb_sync_c = sync_q[SYNC_STAGES-1];
    assign armed_c     = (arm_q == ARM_W'(ARM_LAST));
    assign event_c     = armed_c && (strb_sync_c != strb_prev_q);

    // Strobe synchroniser and post-reset arming counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            arm_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], strb_in};
            if (!armed_c) begin
                arm_q <= arm_q + ARM_W'(1);
            end
        end
    end

    // Next-state and next-output logic for the frame parser
    always_comb begin
        state_d     = state_q;
        accept_c    = 1'b0;
        ack_d       = ack_q;
        wr_en_d     = 1'b0;
        wr_data_d   = wr_data_q;
        len_d       = len_q;
        start_d     = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        byte_cnt_d  = byte_cnt_q;
        tmo_d       = tmo_q;
        strb_prev_d = strb_prev_q;

        case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                if (event_c) begin
                    accept_c = 1'b1;
                    if (data_in == HEADER) begin
                        start_d = 1'b1;
                        state_d = ST_LEN_H;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LEN_H: begin
                if (event_c) begin
                    accept_c     = 1'b1;
                    len_d[15:8]  = data_in;
                    state_d      = ST_LEN_L;
                end
            end
            ST_LEN_L: begin
                if (event_c) begin
                    accept_c    = 1'b1;
                    len_d[7:0]  = data_in;
                    byte_cnt_d  = {len_q[15:8], data_in};
                    if ({len_q[15:8], data_in} == 16'd0) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (event_c && !fifo_full) begin
                    accept_c   = 1'b1;
                    wr_en_d    = 1'b1;
                    wr_data_d  = data_in;
                    byte_cnt_d = byte_cnt_q - CNT_W'(1);
                    if (byte_cnt_q == CNT_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Inter-byte watchdog inside a frame; an accepted byte always wins
        if (state_q != ST_IDLE) begin
            if (accept_c) begin
                tmo_d = '0;
            end else if (tmo_q == CNT_W'(TIMEOUT - 1)) begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + CNT_W'(1);
            end
        end

        if (accept_c) begin
            ack_d = ~ack_q;
        end
        if (!armed_c || accept_c) begin
            strb_prev_d = strb_sync_c;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            strb_prev_q <= 1'b0;
            byte_cnt_q  <= '0;
            tmo_q       <= '0;
            ack_q       <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            len_q       <= '0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            strb_prev_q <= strb_prev_d;
            byte_cnt_q  <= byte_cnt_d;
            tmo_q       <= tmo_d;
            ack_q       <= ack_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            len_q       <= len_d;
            start_q     <= start_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign ack_out     = ack_q;
    assign wr_en       = wr_en_q;
    assign wr_data     = wr_data_q;
    assign len_out     = len_q;
    assign frame_start = start_q;
    assign frame_done  = done_q;
    assign frame_err   = err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_ar9331_rx_link.sv
// Scoreboard bench for ar9331_rx_link: frames are described at the
// protocol level, expected writes/events are queued, a monitor checks them.
module tb_ar9331_rx_link;

    localparam int unsigned TMO = 100;
    localparam int unsigned SYN = 2;
    localparam int unsigned LAT = SYN + 1;

    localparam int EV_START = 1;
    localparam int EV_DONE  = 2;
    localparam int EV_ERR   = 3;

    typedef struct {
        int          kind;
        logic [15:0] len;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        strb_in = 1'b1;
    logic [7:0]  data_in = 8'h00;
    logic        ack_out;
    logic        fifo_full;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic [15:0] len_out;
    logic        frame_start;
    logic        frame_done;
    logic        frame_err;
    logic        busy;

    logic force_full = 1'b0;
    logic rand_en    = 1'b0;
    logic rand_full  = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] wr_q[$];
    ev_t        ev_q[$];

    assign fifo_full = rand_en ? rand_full : force_full;

    ar9331_rx_link #(
        .SYNC_STAGES(SYN),
        .HEADER     (8'h36),
        .TIMEOUT    (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .strb_in    (strb_in),
        .data_in    (data_in),
        .ack_out    (ack_out),
        .fifo_full  (fifo_full),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .len_out    (len_out),
        .frame_start(frame_start),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Random back-pressure source
    always @(negedge clk) rand_full <= ($urandom_range(0, 3) == 0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a write or pulse
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (wr_en) begin
                if (wr_q.size() == 0) check("unexpected_wr", 32'(wr_data), 32'hFFFF_FFFF);
                else check("wr_data", 32'(wr_data), 32'(wr_q.pop_front()));
            end
            if (frame_start) begin
                if (ev_q.size() == 0) check("unexpected_start", 1, 0);
                else check("start_kind", EV_START, ev_q.pop_front().kind);
            end
            if (frame_done) begin
                if (ev_q.size() == 0) check("unexpected_done", 1, 0);
                else begin
                    ev_t e;
                    e = ev_q.pop_front();
                    check("done_kind", EV_DONE, e.kind);
                    check("done_len", 32'(len_out), 32'(e.len));
                    check("done_with_wr", 32'(wr_en), 32'(e.len != 16'd0));
                end
            end
            if (frame_err) begin
                if (ev_q.size() == 0) check("unexpected_err", 1, 0);
                else check("err_kind", EV_ERR, ev_q.pop_front().kind);
            end
        end
    end

    function automatic void push_ev(input int kind, input logic [15:0] len);
        ev_t e;
        e.kind = kind;
        e.len  = len;
        ev_q.push_back(e);
    endfunction

    // Present one byte by toggling the strobe and wait (bounded) for the ack toggle
    task automatic send_byte(input logic [7:0] b, input int lat_exp);
        logic ack0;
        int   cyc;
        @(negedge clk);
        if (lat_exp == 0) repeat ($urandom_range(0, 2)) @(negedge clk);
        data_in = b;
        ack0    = ack_out;
        strb_in = ~strb_in;
        cyc     = 0;
        while (ack_out == ack0 && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (ack_out == ack0) check("ack_timeout", 32'(cyc), 32'(lat_exp));
        else if (lat_exp > 0) check("ack_latency", 32'(cyc), 32'(lat_exp));
    endtask

    // Expect a watchdog error exactly TMO cycles after the last accepted byte
    task automatic wait_timeout();
        int cyc = 0;
        while (!frame_err && cyc < 3 * TMO) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("timeout_cycles", 32'(cyc), 32'(TMO));
        check("busy_after_tmo", 32'(busy), 32'd0);
    endtask

    // Complete frame: model says start, every payload byte written, done with len
    task automatic good_frame(input logic [15:0] len, input int lat);
        logic [7:0] pl[$];
        for (int i = 0; i < int'(len); i++) pl.push_back(8'($urandom));
        push_ev(EV_START, 16'd0);
        foreach (pl[i]) wr_q.push_back(pl[i]);
        push_ev(EV_DONE, len);
        send_byte(8'h36, lat);
        send_byte(len[15:8], lat);
        send_byte(len[7:0], lat);
        foreach (pl[i]) send_byte(pl[i], lat);
    endtask

    // Frame abandoned after n_sent bytes (header counts as one)
    task automatic trunc_frame(input logic [15:0] len, input int n_sent);
        logic [7:0] b;
        push_ev(EV_START, 16'd0);
        send_byte(8'h36, 0);
        if (n_sent > 1) send_byte(len[15:8], 0);
        if (n_sent > 2) send_byte(len[7:0], 0);
        for (int i = 3; i < n_sent; i++) begin
            b = 8'($urandom);
            wr_q.push_back(b);
            send_byte(b, 0);
        end
        push_ev(EV_ERR, 16'd0);
        wait_timeout();
    endtask

    initial begin
        logic [7:0] bad;
        int         kind;

        // Reset with strobe held high
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(ack_out), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_len", 32'(len_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pulses", 32'({frame_start, frame_done, frame_err}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("no_ack_after_arm", 32'(ack_out), 32'd0);
        check("idle_after_arm", 32'(busy), 32'd0);

        // Basic 3-byte frame; first strobe edge is 1->0
        push_ev(EV_START, 16'd0);
        wr_q.push_back(8'hA1); wr_q.push_back(8'hA2); wr_q.push_back(8'hA3);
        push_ev(EV_DONE, 16'd3);
        send_byte(8'h36, LAT);
        check("busy_in_frame", 32'(busy), 32'd1);
        send_byte(8'h00, LAT);
        send_byte(8'h03, LAT);
        send_byte(8'hA1, LAT);
        send_byte(8'hA2, LAT);
        send_byte(8'hA3, LAT);
        check("ack_after_6", 32'(ack_out), 32'd0);
        check("len_hold", 32'(len_out), 32'h0003);

        // Zero-length frame
        good_frame(16'd0, LAT);
        check("busy_zero_len", 32'(busy), 32'd0);

        // Bad header followed by a valid frame
        push_ev(EV_ERR, 16'd0);
        send_byte(8'h55, LAT);
        check("busy_bad_hdr", 32'(busy), 32'd0);
        good_frame(16'd2, LAT);

        // Back-pressure on the second payload byte
        push_ev(EV_START, 16'd0);
        wr_q.push_back(8'hC1); wr_q.push_back(8'hC2); wr_q.push_back(8'hC3);
        push_ev(EV_DONE, 16'd3);
        send_byte(8'h36, LAT);
        send_byte(8'h00, LAT);
        send_byte(8'h03, LAT);
        send_byte(8'hC1, LAT);
        @(negedge clk);
        force_full = 1'b1;
        fork
            begin
                @(negedge clk);
                repeat (10) @(posedge clk);
                @(negedge clk);
                force_full = 1'b0;
            end
        join_none
        send_byte(8'hC2, 11);
        send_byte(8'hC3, LAT);

        // Stall after the length bytes
        trunc_frame(16'd5, 3);

        // Randomized frames under random back-pressure
        for (int f = 0; f < 30; f++) begin
            kind = $urandom_range(0, 5);
            if (kind == 0) begin
                bad = 8'($urandom);
                if (bad == 8'h36) bad = 8'h37;
                push_ev(EV_ERR, 16'd0);
                send_byte(bad, 0);
            end else if (kind == 1) begin
                trunc_frame(16'($urandom_range(1, 6)), $urandom_range(1, 3));
            end else if (kind == 2) begin
                trunc_frame(16'd8, $urandom_range(4, 10));
            end else begin
                rand_en = 1'b1;
                good_frame(16'($urandom_range(0, 9)), 0);
                @(negedge clk);
                rand_en = 1'b0;
            end
        end

        repeat (20) @(posedge clk);
        #1;
        check("wr_q_drained", 32'(wr_q.size()), 32'd0);
        check("ev_q_drained", 32'(ev_q.size()), 32'd0);
        check("final_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ar9331_rx_link.md
# ar9331_rx_link

Receive side of the FPGA↔AR9331 parallel toggle-handshake link: the AR9331 drives a byte on `data_in`, toggles `strb_in`, and waits for `ack_out` to toggle. The block synchronises the strobe, parses frames (header 0x36, 16-bit length, payload), and pushes payload bytes into a downstream command FIFO with back-pressure. It sits between the AR9331 GPIO bus and the FPGA command/config logic, and mirrors the FPGA→AR9331 transmit path.

## Interface
- `SYNC_STAGES`, 2: flip-flops in the `strb_in` synchroniser (≥2).
- `HEADER`, 8'd54: frame start byte.
- `TIMEOUT`, 65535: idle clk cycles allowed between bytes inside a frame (1..65535).

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `strb_in`  in  1  AR9331 byte strobe (toggle = new byte), asynchronous.
- `data_in`  in  8  AR9331 byte; stable from before strobe toggle until ack toggle.
- `ack_out`  out  1  toggles once per accepted byte.
- `fifo_full`  in  1  downstream FIFO full.
- `wr_en`  out  1  one-cycle write strobe for a payload byte.
- `wr_data`  out  8  payload byte, valid with `wr_en`.
- `len_out`  out  16  length of the current/last frame.
- `frame_start`  out  1  one-cycle pulse: valid header accepted.
- `frame_done`  out  1  one-cycle pulse: last payload byte written (or zero-length frame).
- `frame_err`  out  1  one-cycle pulse: bad header or timeout.
- `busy`  out  1  high in any state except IDLE.

## Operation
- Reset values: `ack_out`=0, `wr_en`=0, `wr_data`=0, `len_out`=0, all pulses 0, `busy`=0, state IDLE, synchroniser and previous-level register 0, byte counter 0, timeout counter 0.
- Byte event: `strb_sync` (last sync stage) ≠ `strb_prev`. Accepting an event sets `strb_prev`←`strb_sync` and toggles `ack_out`, both on the same edge. An unaccepted event stays pending.
- Arming: event detection is disabled for the first SYNC_STAGES+1 cycles after reset; during them `strb_prev` tracks `strb_sync`, so a strobe held high at reset is not a byte.
- States:
  - IDLE: on event, if `data_in`==HEADER, pulse `frame_start` and go to LEN_H; else pulse `frame_err` and stay. Ack in both cases.
  - LEN_H: on event, `len_out[15:8]`←`data_in`, ack, go to LEN_L.
  - LEN_L: on event, `len_out[7:0]`←`data_in`, counter←{`len_out[15:8]`,`data_in`}, ack. If the length is 0, pulse `frame_done` and go to IDLE; else go to PAYLOAD.
  - PAYLOAD: on event with `fifo_full`=0: `wr_en`=1, `wr_data`←`data_in`, ack, counter−1. When the counter reaches 0, pulse `frame_done` (same edge as the last `wr_en`) and go to IDLE. With `fifo_full`=1 the event is held: no ack, no write.
- Timeout: in LEN_H/LEN_L/PAYLOAD the counter clears on every accepted event and increments otherwise. It also increments while an event is held for `fifo_full`. When it reaches TIMEOUT, pulse `frame_err` and go to IDLE. A pending event is then handled as a header candidate in IDLE.
- Counter widths: byte counter 16 bits, timeout counter 16 bits; no wrap is possible because both saturate by state exit.

## Timing
- `strb_in` toggle is first captured at edge 1, so `ack_out` toggles and `wr_en` asserts at edge SYNC_STAGES+1 (edge 3 by default), unless back-pressured.
- While back-pressured, the action occurs on the first edge at which `fifo_full` was sampled 0.
- Maximum throughput: one byte per 2·(SYNC_STAGES+1) clk cycles, bounded by the AR9331 round trip.
- `wr_data` is sampled directly from `data_in` on the accept edge; the protocol guarantees ≥SYNC_STAGES cycles of stability.
- Reset mid-frame: everything returns to reset values immediately, and the AR9331 must restart the link with `strb_in` at its current level.

## Test plan
- Frame 0x36, 0x00, 0x03, bytes A1 A2 A3, one toggle per ack → `frame_start` after byte 1, three `wr_en` with A1/A2/A3, `frame_done` coincident with A3, `len_out`=0x0003, 6 ack toggles.
- Zero-length frame 0x36, 0x00, 0x00 → `frame_done` on the LEN_L accept edge, no `wr_en`, 3 acks.
- Bad header 0x55 in IDLE → `frame_err` pulse, ack toggles, state stays IDLE; a following valid frame is received correctly.
- `fifo_full`=1 for 10 cycles during the 2nd payload byte → no ack and no write until `fifo_full` drops; then `wr_en` and ack on the next edge, data intact.
- Stop after the length bytes (len=5) and wait TIMEOUT=100 cycles → `frame_err` at cycle 100, `busy`=0; no `wr_en`.
- `strb_in`=1 while `rst_n` is deasserted → no event, no ack after arming; the first real toggle (1→0) is treated as a byte.
